// File: rtl/bcd_tube_driver.sv
// bcd_tube_driver: double-dabble binary-to-BCD converter feeding a scanned 4-digit active-low 7-segment display
module bcd_tube_driver #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state;
  logic [15:0] cap, sh, disp;
  logic [19:0] bcd, bcd_adj;
  logic [3:0]  it, dig;
  logic        frc, show, wrap;
  logic [7:0]  scan_cnt, code;
  logic [1:0]  idx;
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++)
      bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] >= 4'd5 ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
  end
  assign wrap = scan_cnt == 8'(SCAN_DIV - 1);
  assign dig  = disp[{idx, 2'b00} +: 4];
  assign show = idx == 2'd0 || (disp >> {idx, 2'b00}) != 16'd0;
  always_comb begin
    case (dig)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap      <= '0;
      sh       <= '0;
      bcd      <= '0;
      disp     <= '0;
      it       <= '0;
      frc      <= 1'b1;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= 8'hFF;
      an       <= 4'hF;
    end else begin
      scan_cnt <= wrap ? 8'd0 : scan_cnt + 8'd1;
      idx      <= wrap ? idx + 2'd1 : idx;
      an       <= ~(4'b0001 << idx);
      seg      <= ovf ? 8'hBF : show ? code : 8'hFF;
      case (state)
        IDLE: if (frc || data_in != cap) begin
          cap   <= data_in;
          sh    <= data_in;
          bcd   <= '0;
          it    <= '0;
          frc   <= 1'b0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, sh} <= {bcd_adj, sh} << 1;
          it        <= it + 4'd1;
          state     <= it == 4'd15 ? DONE : SHIFT;
        end
        DONE: begin
          disp  <= bcd[15:0];
          ovf   <= bcd[19:16] != 4'd0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_tube_driver.sv
// tb_bcd_tube_driver: randomized checks of three scan rates against a decimal-arithmetic display model
module tb_bcd_tube_driver;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [7:0]  seg, seg1, seg7;
  logic [3:0]  an, an1, an7;
  logic        busy, busy1, busy7, ovf, ovf1, ovf7;
  int          total = 0, bad = 0;
  logic [7:0]  codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int          m_val, m_run, ph4, ph1, ph7;
  logic [15:0] m_cap;
  logic        m_force, m_busy, m_ovf;
  logic [7:0]  m_seg, m_seg1, m_seg7;
  logic [3:0]  m_an, m_an1, m_an7;

  always #5 clk = ~clk;

  bcd_tube_driver #(.SCAN_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .data_in(data_in), .seg(seg), .an(an), .busy(busy), .ovf(ovf));
  bcd_tube_driver #(.SCAN_DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .data_in(data_in), .seg(seg1), .an(an1), .busy(busy1), .ovf(ovf1));
  bcd_tube_driver #(.SCAN_DIV(7)) u7 (.clk(clk), .rst_n(rst_n), .data_in(data_in), .seg(seg7), .an(an7), .busy(busy7), .ovf(ovf7));

  function automatic logic [7:0] seg_for(int v, logic o, int k);
    int p;
    p = 10 ** k;
    if (o) return 8'hBF;
    if (k > 0 && v < p) return 8'hFF;
    return codes[(v / p) % 10];
  endfunction

  function automatic logic [3:0] an_for(int ph, int sd);
    return ~(4'b0001 << ((ph / sd) % 4));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model();
    if (!rst_n) begin
      m_val = 0; m_ovf = 1'b0; m_busy = 1'b0; m_force = 1'b1; m_cap = '0; m_run = 0;
      ph4 = 0; ph1 = 0; ph7 = 0;
      m_seg = 8'hFF; m_seg1 = 8'hFF; m_seg7 = 8'hFF;
      m_an = 4'hF; m_an1 = 4'hF; m_an7 = 4'hF;
    end else begin
      m_seg  = seg_for(m_val, m_ovf, (ph4 / 4) % 4);
      m_seg1 = seg_for(m_val, m_ovf, ph1 % 4);
      m_seg7 = seg_for(m_val, m_ovf, (ph7 / 7) % 4);
      m_an = an_for(ph4, 4); m_an1 = an_for(ph1, 1); m_an7 = an_for(ph7, 7);
      ph4 = (ph4 + 1) % 16; ph1 = (ph1 + 1) % 4; ph7 = (ph7 + 1) % 28;
      if (m_run == 0) begin
        if (m_force || data_in != m_cap) begin
          m_cap = data_in; m_force = 1'b0; m_run = 17; m_busy = 1'b1;
        end
      end else begin
        m_run--;
        if (m_run == 0) begin
          m_val = int'(m_cap); m_ovf = m_cap > 16'd9999; m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    check("seg", seg, m_seg);
    check("an", an, m_an);
    check("busy", busy, m_busy);
    check("ovf", ovf, m_ovf);
    check("seg_div1", seg1, m_seg1);
    check("an_div1", an1, m_an1);
    check("busy_div1", busy1, m_busy);
    check("ovf_div1", ovf1, m_ovf);
    check("seg_div7", seg7, m_seg7);
    check("an_div7", an7, m_an7);
    check("busy_div7", busy7, m_busy);
    check("ovf_div7", ovf7, m_ovf);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; data_in = 16'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (34) tick();
    data_in = 16'd1234;
    repeat (40) tick();
    data_in = 16'd65535;
    repeat (40) tick();
    data_in = 16'd9999;
    repeat (5) tick();
    data_in = 16'd42;
    repeat (60) tick();
    data_in = 16'd500;
    repeat (8) tick();
    rst_n = 1'b0; data_in = 16'd777;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 3);
      data_in = r == 0 ? 16'($urandom) : r == 1 ? 16'($urandom_range(0, 9)) :
                r == 2 ? 16'($urandom_range(0, 999)) : 16'($urandom_range(0, 9999));
      repeat ($urandom_range(1, 30)) tick();
    end
    data_in = 16'd10000;
    repeat (40) tick();
    data_in = 16'd0;
    repeat (40) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_tube_driver.md
BCD_TUBE_DRIVER -- requirements
Module: bcd_tube_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, meaning clk cycles each digit stays selected (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port data_in, input, 16 bits: unsigned binary value to display.
REQ-005 SHALL have port seg, output, 8 bits: segment drive, active-low; seg[7]=dp, seg[6:0]=g..a.
REQ-006 SHALL have port an, output, 4 bits: digit select, active-low one-hot; an[0] is the rightmost digit.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port ovf, output, 1 bit: high while the committed value exceeds 9999.

Function
REQ-009 SHALL hold a captured register cap[15:0] and a force flag; FSM states IDLE, SHIFT, DONE.
REQ-010 IDLE: if force=1 or data_in != cap, SHALL load cap and shifter with data_in, clear the 20-bit BCD accumulator, clear force, go to SHIFT; otherwise stay in IDLE.
REQ-011 SHIFT: SHALL run exactly 16 double-dabble iterations, one per cycle, then go to DONE.
REQ-012 Each iteration SHALL add 3 to every BCD nibble >=5, then shift {bcd,shifter} left by 1.
REQ-013 DONE: SHALL commit the 5 BCD digits to the display register, update ovf, and return to IDLE in 1 cycle.
REQ-014 Latency: capture at edge N SHALL produce the committed display at edge N+17; busy SHALL be high from edge N through N+16, low after N+17.
REQ-015 data_in changes during SHIFT/DONE SHALL be ignored; the IDLE comparison after DONE SHALL start a new conversion if data_in != cap.
REQ-016 ovf SHALL be set when the committed ten-thousands digit is nonzero (value 10000..65535).
REQ-017 When ovf=1, all four digits SHALL show a dash (seg=8'hBF).
REQ-018 Leading-zero blanking: digits above the most significant nonzero digit SHALL show blank (8'hFF); digit 0 SHALL always be shown, so value 0 displays "0".
REQ-019 Digit codes (dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF, blank=FF.
REQ-020 Scan: an 8-bit counter SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-021 an and seg SHALL be registered and SHALL reflect the current digit index and the display register one cycle after the index changes.
REQ-022 Exactly one an bit SHALL be low at all times outside reset.
REQ-023 The display register SHALL change only at DONE, so the scan never shows a partially converted value.

Reset
REQ-024 While rst_n=0 at an edge, the block SHALL drive seg=8'hFF and an=4'hF, and set busy=0, ovf=0, display register=0, cap=0, state=IDLE, scan counter=0, digit index=0, force=1.
REQ-025 On the first edge with rst_n=1, the block SHALL start a conversion of data_in (because force=1).
REQ-026 Reset asserted mid-conversion SHALL abort the conversion and discard the partial result; the display register SHALL read 0.

Verification
REQ-027 Reset with data_in=0, release, wait 18 cycles -> busy=0, ovf=0; over 4*SCAN_DIV cycles an[0] shows C0 and an[1..3] show FF.
REQ-028 data_in=1234 -> busy high 17 cycles; digits 3..0 = F9, A4, B0, 99; ovf=0.
REQ-029 data_in=65535 -> ovf=1; all four digits BF.
REQ-030 data_in=9999, then 42 applied at cycle 5 of the conversion -> 9999 commits first (90 x4), then a second conversion commits 42 (digits FF, FF, 99, A4).
REQ-031 rst_n low at cycle 8 of a conversion of 500 -> seg=FF, an=F; after release, conversion restarts from the current data_in.
REQ-032 SCAN_DIV=1 and SCAN_DIV=7 -> an rotates 1110, 1101, 1011, 0111 with each digit low for exactly SCAN_DIV cycles.
